// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: per-register in-flight write counts gate issue on RAW hazards
// and saturated WAW counts, with same-cycle release from writeback and kill.
module reg_scoreboard #(
    parameter int PEND_W = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        id_valid,
    input  logic [4:0]  id_rj,
    input  logic [4:0]  id_rk,
    input  logic        id_rj_used,
    input  logic        id_rk_used,
    input  logic [4:0]  id_rd,
    input  logic        id_rd_we,
    output logic        id_ready,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic        kill_valid,
    input  logic [4:0]  kill_rd,
    output logic [31:0] busy,
    output logic [31:0] stall_cnt,
    output logic        err
);

    // Handshake: an instruction issues (fire) on any cycle with id_valid & id_ready;
    // id_ready never looks at id_valid, and decode holds id_* stable until fire.
    localparam logic [PEND_W:0] MAX_EXT = {1'b0, {PEND_W{1'b1}}};

    logic [31:1][PEND_W-1:0] cnt_q;
    logic [31:1][PEND_W-1:0] cnt_d;
    logic [31:1]             dec_wb;
    logic [31:1]             dec_kill;
    logic [31:1]             inc;
    logic [31:1]             uflow;
    logic [31:0]             eff_nz;
    logic [31:0]             eff_full;
    logic [PEND_W:0]         e_cur;
    logic [PEND_W:0]         e_dn;
    logic [PEND_W:0]         n_up;
    logic [PEND_W:0]         n_dn;
    logic                    rj_haz;
    logic                    rk_haz;
    logic                    waw_full;
    logic                    fire;

    // Effective count after this cycle's writeback/kill, used only for the issue decision.
    always_comb begin
        dec_wb   = '0;
        dec_kill = '0;
        eff_nz   = '0;
        eff_full = '0;
        e_cur    = '0;
        e_dn     = '0;
        for (int r = 1; r < 32; r++) begin
            dec_wb[r]   = wb_we & (wb_rd == 5'(r));
            dec_kill[r] = kill_valid & (kill_rd == 5'(r));
            e_cur       = {1'b0, cnt_q[r]};
            e_dn        = (PEND_W+1)'(dec_wb[r]) + (PEND_W+1)'(dec_kill[r]);
            eff_nz[r]   = e_cur > e_dn;
            eff_full[r] = (e_cur >= e_dn) && ((e_cur - e_dn) == MAX_EXT);
        end
    end

    assign rj_haz   = id_rj_used & (id_rj != 5'd0) & eff_nz[id_rj];
    assign rk_haz   = id_rk_used & (id_rk != 5'd0) & eff_nz[id_rk];
    assign waw_full = id_rd_we & (id_rd != 5'd0) & eff_full[id_rd];
    assign id_ready = ~rj_haz & ~rk_haz & ~waw_full;
    assign fire     = id_valid & id_ready;

    // Next counts; a decrement below zero clamps to 0 and flags a protocol error.
    always_comb begin
        inc   = '0;
        uflow = '0;
        cnt_d = '0;
        n_up  = '0;
        n_dn  = '0;
        for (int r = 1; r < 32; r++) begin
            inc[r] = fire & id_rd_we & (id_rd == 5'(r));
            n_up   = {1'b0, cnt_q[r]} + (PEND_W+1)'(inc[r]);
            n_dn   = (PEND_W+1)'(dec_wb[r]) + (PEND_W+1)'(dec_kill[r]);
            if (n_up < n_dn) begin
                uflow[r] = 1'b1;
                cnt_d[r] = '0;
            end else begin
                cnt_d[r] = PEND_W'(n_up - n_dn);
            end
        end
    end

    always_comb begin
        busy    = '0;
        for (int r = 1; r < 32; r++) begin
            busy[r] = |cnt_q[r];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q     <= '0;
            stall_cnt <= '0;
            err       <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (id_valid && !id_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (|uflow) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: a table of per-cycle vectors with hand-computed
// ready/busy values, plus sequences for underflow and asynchronous reset.
module tb_reg_scoreboard;

    logic        clk;
    logic        rstn;
    logic        id_valid;
    logic [4:0]  id_rj;
    logic [4:0]  id_rk;
    logic        id_rj_used;
    logic        id_rk_used;
    logic [4:0]  id_rd;
    logic        id_rd_we;
    logic        id_ready;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic        kill_valid;
    logic [4:0]  kill_rd;
    logic [31:0] busy;
    logic [31:0] stall_cnt;
    logic        err;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_stall;

    reg_scoreboard #(.PEND_W(2)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .id_valid   (id_valid),
        .id_rj      (id_rj),
        .id_rk      (id_rk),
        .id_rj_used (id_rj_used),
        .id_rk_used (id_rk_used),
        .id_rd      (id_rd),
        .id_rd_we   (id_rd_we),
        .id_ready   (id_ready),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .kill_valid (kill_valid),
        .kill_rd    (kill_rd),
        .busy       (busy),
        .stall_cnt  (stall_cnt),
        .err        (err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [4:0]  rj;
        logic        rju;
        logic [4:0]  rk;
        logic        rku;
        logic [4:0]  rd;
        logic        rdwe;
        logic        wbwe;
        logic [4:0]  wbrd;
        logic        kv;
        logic [4:0]  krd;
        logic        exp_ready;
        logic [31:0] exp_busy;
    } vec_t;

    vec_t vecs[24];

    function automatic logic [31:0] b(input int r);
        return 32'h1 << r;
    endfunction

    function automatic vec_t mk(input logic v, input logic [4:0] rj, input logic rju,
                                input logic [4:0] rk, input logic rku,
                                input logic [4:0] rd, input logic rdwe,
                                input logic wbwe, input logic [4:0] wbrd,
                                input logic kv, input logic [4:0] krd,
                                input logic er, input logic [31:0] eb);
        vec_t t;
        t.v = v; t.rj = rj; t.rju = rju; t.rk = rk; t.rku = rku;
        t.rd = rd; t.rdwe = rdwe; t.wbwe = wbwe; t.wbrd = wbrd;
        t.kv = kv; t.krd = krd; t.exp_ready = er; t.exp_busy = eb;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic drive(input vec_t t);
        id_valid   = t.v;
        id_rj      = t.rj;
        id_rj_used = t.rju;
        id_rk      = t.rk;
        id_rk_used = t.rku;
        id_rd      = t.rd;
        id_rd_we   = t.rdwe;
        wb_we      = t.wbwe;
        wb_rd      = t.wbrd;
        kill_valid = t.kv;
        kill_rd    = t.krd;
    endtask

    task automatic idle();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] eb;

        // v   rj rju rk rku rd rdwe wbwe wbrd kv krd  ready busy_next
        vecs[0]  = mk(1,  0, 0,  0, 0,  5, 1,  0, 0,  0, 0,  1, b(5));
        vecs[1]  = mk(1,  5, 1,  0, 0,  0, 0,  0, 0,  0, 0,  0, b(5));
        vecs[2]  = mk(1,  5, 1,  0, 0,  0, 0,  0, 0,  0, 0,  0, b(5));
        vecs[3]  = mk(1,  5, 1,  0, 0,  0, 0,  1, 5,  0, 0,  1, 0);
        vecs[4]  = mk(1,  0, 0,  0, 0,  0, 1,  0, 0,  0, 0,  1, 0);
        vecs[5]  = mk(1,  0, 1,  0, 1,  0, 1,  0, 0,  0, 0,  1, 0);
        vecs[6]  = mk(1,  0, 0,  0, 0,  7, 1,  0, 0,  0, 0,  1, b(7));
        vecs[7]  = mk(1,  0, 0,  0, 0,  7, 1,  0, 0,  0, 0,  1, b(7));
        vecs[8]  = mk(1,  0, 0,  0, 0,  7, 1,  0, 0,  0, 0,  1, b(7));
        vecs[9]  = mk(1,  0, 0,  0, 0,  7, 1,  0, 0,  0, 0,  0, b(7));
        vecs[10] = mk(1,  0, 0,  0, 0,  7, 1,  1, 7,  0, 0,  1, b(7));
        vecs[11] = mk(1,  7, 1,  0, 0,  7, 1,  0, 0,  0, 0,  0, b(7));
        vecs[12] = mk(0,  0, 0,  0, 0,  0, 0,  1, 7,  0, 0,  1, b(7));
        vecs[13] = mk(0,  0, 0,  0, 0,  0, 0,  1, 7,  1, 7,  1, 0);
        vecs[14] = mk(1,  0, 0,  0, 0,  9, 1,  0, 0,  0, 0,  1, b(9));
        vecs[15] = mk(1,  0, 0,  7, 1,  9, 1,  0, 0,  0, 0,  1, b(9));
        vecs[16] = mk(1,  9, 1,  9, 1,  0, 0,  1, 9,  1, 9,  1, 0);
        vecs[17] = mk(1, 12, 1,  0, 0, 12, 1,  0, 0,  0, 0,  1, b(12));
        vecs[18] = mk(1,  0, 0, 12, 1,  0, 0,  0, 0,  1, 12, 1, 0);
        vecs[19] = mk(1,  0, 0,  0, 0, 12, 1,  0, 0,  0, 0,  1, b(12));
        vecs[20] = mk(1,  0, 0,  0, 0, 12, 1,  0, 0,  0, 0,  1, b(12));
        vecs[21] = mk(1,  0, 0,  0, 0, 12, 1,  1, 12, 1, 12, 1, b(12));
        vecs[22] = mk(1,  0, 0, 12, 1,  0, 0,  0, 0,  0, 0,  0, b(12));
        vecs[23] = mk(1,  0, 0, 12, 1,  0, 0,  1, 12, 0, 0,  1, 0);

        rstn = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        step();
        chk("reset_busy", busy, 32'd0);
        chk("reset_stall", stall_cnt, 32'd0);
        chk("reset_err", {31'd0, err}, 32'd0);
        chk("reset_ready", {31'd0, id_ready}, 32'd1);

        exp_stall = 32'd0;
        for (int i = 0; i < 24; i++) begin
            drive(vecs[i]);
            exp_q.push_back(vecs[i].exp_busy);
            if (vecs[i].v && !vecs[i].exp_ready) exp_stall++;
            #1;
            chk($sformatf("ready_v%0d", i), {31'd0, id_ready}, {31'd0, vecs[i].exp_ready});
            step();
            eb = exp_q.pop_front();
            chk($sformatf("busy_v%0d", i), busy, eb);
            chk($sformatf("stall_v%0d", i), stall_cnt, exp_stall);
            chk($sformatf("err_v%0d", i), {31'd0, err}, 32'd0);
        end

        // Writeback to an idle register: sticky error, count stays 0.
        idle();
        wb_we = 1'b1;
        wb_rd = 5'd3;
        step();
        idle();
        chk("uflow_err", {31'd0, err}, 32'd1);
        chk("uflow_busy", busy, 32'd0);
        repeat (3) step();
        chk("uflow_err_sticky", {31'd0, err}, 32'd1);
        chk("uflow_busy_hold", busy, 32'd0);

        // Pend r4 and r6, stall on r4, then reset asynchronously mid-cycle.
        drive(mk(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 1, 0));
        step();
        drive(mk(1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0, 1, 0));
        step();
        chk("pend_busy", busy, b(4) | b(6));
        drive(mk(1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("pre_rst_ready", {31'd0, id_ready}, 32'd0);
        step();
        chk("pre_rst_stall", stall_cnt, exp_stall + 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_busy", busy, 32'd0);
        chk("async_stall", stall_cnt, 32'd0);
        chk("async_err", {31'd0, err}, 32'd0);
        chk("async_ready", {31'd0, id_ready}, 32'd1);
        idle();
        @(negedge clk);
        rstn = 1'b1;
        step();
        // Late writeback of a pre-reset instruction counts as underflow.
        wb_we = 1'b1;
        wb_rd = 5'd4;
        step();
        idle();
        chk("post_rst_err", {31'd0, err}, 32'd1);
        chk("post_rst_busy", busy, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
